// File: rtl/font_rom_arbiter_if.sv
// Bundle between the two score text generators, the arbiter and the digit font ROM.
interface font_rom_arbiter_if;
  logic        req0;
  logic [3:0]  digit0;
  logic [3:0]  row0;
  logic        req1;
  logic [3:0]  digit1;
  logic [3:0]  row1;
  logic        gnt0;
  logic        gnt1;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  rdata;
  logic        rvalid0;
  logic        rvalid1;

  modport master (
    output req0, digit0, row0, req1, digit1, row1, rom_data,
    input  gnt0, gnt1, rom_addr, rdata, rvalid0, rvalid1
  );

  modport slave (
    input  req0, digit0, row0, req1, digit1, row1, rom_data,
    output gnt0, gnt1, rom_addr, rdata, rvalid0, rvalid1
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Round-robin sharing of one digit font ROM between two score renderers,
// with a tag pipeline that routes each returned glyph row to its requester.
module font_rom_arbiter #(
  parameter int          ROM_LAT    = 1,
  parameter logic [7:0]  BLANK_CODE = 8'h00
) (
  input logic               clk,
  input logic               reset,
  font_rom_arbiter_if.slave bus
);

  logic               last_gnt_q, last_gnt_d;
  logic [ROM_LAT-1:0] vld_q, vld_d;
  logic [ROM_LAT-1:0] id_q, id_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rvalid0_q, rvalid0_d;
  logic               rvalid1_q, rvalid1_d;
  logic               gnt0, gnt1;
  logic [10:0]        rom_addr;

  function automatic logic [10:0] glyph_addr(input logic [3:0] digit, input logic [3:0] row);
    logic [6:0] code;
    code = (digit <= 4'd9) ? (7'h30 + {3'b000, digit}) : BLANK_CODE[6:0];
    return {code, row};
  endfunction

  // On a tie the requester that was not served last wins; last_gnt_q = 1 means req1 was.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = bus.req0 && (!bus.req1 || last_gnt_q);
      gnt1 = bus.req1 && (!bus.req0 || !last_gnt_q);
    end
  end

  always_comb begin
    rom_addr   = 11'd0;
    last_gnt_d = last_gnt_q;
    if (gnt0) begin
      rom_addr   = glyph_addr(bus.digit0, bus.row0);
      last_gnt_d = 1'b0;
    end else if (gnt1) begin
      rom_addr   = glyph_addr(bus.digit1, bus.row1);
      last_gnt_d = 1'b1;
    end
  end

  // Tag stage ROM_LAT-1 lines up with rom_data for the same read.
  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = gnt0 | gnt1;
    id_d[0]  = gnt1;
    for (int i = 1; i < ROM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
    rvalid0_d = vld_q[ROM_LAT-1] & ~id_q[ROM_LAT-1];
    rvalid1_d = vld_q[ROM_LAT-1] &  id_q[ROM_LAT-1];
    rdata_d   = vld_q[ROM_LAT-1] ? bus.rom_data : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
      vld_q      <= '0;
      id_q       <= '0;
      rdata_q    <= 8'h00;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      vld_q      <= vld_d;
      id_q       <= id_d;
      rdata_q    <= rdata_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rom_addr = rom_addr;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: directed scenarios on 1- and 3-cycle ROM builds plus
// a randomized run against a queue-based response model.
module tb_font_rom_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] mem [0:2047];

  always #5 clk = ~clk;

  font_rom_arbiter_if if1 ();
  font_rom_arbiter_if if3 ();

  font_rom_arbiter #(.ROM_LAT(1), .BLANK_CODE(8'h00)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  font_rom_arbiter #(.ROM_LAT(3), .BLANK_CODE(8'h00)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  // ROM models: registered address, data LAT cycles later.
  logic [7:0] rp1;
  logic [7:0] rp3 [0:2];
  always @(posedge clk) begin
    rp1    <= mem[if1.rom_addr];
    rp3[0] <= mem[if3.rom_addr];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign if1.rom_data = rp1;
  assign if3.rom_data = rp3[2];

  typedef struct {
    bit         id;
    logic [7:0] data;
    int         due;
  } rsp_t;

  function automatic logic [10:0] ref_addr(input int digit, input int row);
    int code;
    code = (digit <= 9) ? 48 + digit : 0;
    return 11'((code % 128) * 16 + row);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r0, input logic [3:0] d0, input logic [3:0] w0,
                     input logic r1, input logic [3:0] d1, input logic [3:0] w1);
    if1.req0 = r0; if1.digit0 = d0; if1.row0 = w0;
    if1.req1 = r1; if1.digit1 = d1; if1.row1 = w1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(1, 5, 5, 1, 2, 2);
    tick(); tick();
    @(negedge clk);
    n_tests++;
    if (if1.gnt0 !== 1'b0 || if1.gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: got %b%b want 00", if1.gnt0, if1.gnt1);
    end
    n_tests++;
    if (if1.rom_addr !== 11'h000) begin
      n_fail++; $display("FAIL reset_addr: got %h want 000", if1.rom_addr);
    end
    n_tests++;
    if (if1.rdata !== 8'h00 || if1.rvalid0 !== 1'b0 || if1.rvalid1 !== 1'b0 || if3.rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_outs: got rdata %h rv %b%b rdata3 %h want 00 00 00", if1.rdata, if1.rvalid0, if1.rvalid1, if3.rdata);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if1.gnt0 !== 1'b1 || if1.gnt1 !== 1'b0 || if1.rom_addr !== 11'h355) begin
      n_fail++; $display("FAIL reset_first_tie: got gnt %b%b addr %h want 10 355", if1.gnt0, if1.gnt1, if1.rom_addr);
    end
    tick();
    drv(0, 0, 0, 1, 2, 2);
    @(negedge clk);
    n_tests++;
    if (if1.gnt1 !== 1'b1 || if1.rom_addr !== 11'h322) begin
      n_fail++; $display("FAIL reset_second: got gnt1 %b addr %h want 1 322", if1.gnt1, if1.rom_addr);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
  endtask

  task automatic test_single();
    drv(1, 0, 2, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (if1.gnt0 !== 1'b1 || if1.gnt1 !== 1'b0 || if1.rom_addr !== 11'h302) begin
      n_fail++; $display("FAIL single_gnt: got gnt %b%b addr %h want 10 302", if1.gnt0, if1.gnt1, if1.rom_addr);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (if1.rvalid0 !== 1'b0) begin
      n_fail++; $display("FAIL single_early: got rvalid0 %b want 0", if1.rvalid0);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (if1.rvalid0 !== 1'b1 || if1.rvalid1 !== 1'b0 || if1.rdata !== 8'h38) begin
      n_fail++; $display("FAIL single_rsp: got rv %b%b rdata %h want 10 38", if1.rvalid0, if1.rvalid1, if1.rdata);
    end
    tick();
  endtask

  task automatic test_alternate();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv(1, 1, 4, 1, 7, 4);
    for (int k = 0; k < 8; k++) begin
      logic eg0, eg1, ev0, ev1;
      logic [7:0] ed;
      eg0 = (k < 4) && (k % 2 == 0);
      eg1 = (k < 4) && (k % 2 == 1);
      ev0 = (k >= 2) && (k < 6) && ((k - 2) % 2 == 0);
      ev1 = (k >= 2) && (k < 6) && ((k - 2) % 2 == 1);
      ed  = ev0 ? 8'h78 : 8'h06;
      @(negedge clk);
      n_tests++;
      if (if1.gnt0 !== eg0 || if1.gnt1 !== eg1) begin
        n_fail++; $display("FAIL alt_gnt[%0d]: got %b%b want %b%b", k, if1.gnt0, if1.gnt1, eg0, eg1);
      end
      n_tests++;
      if (if1.rvalid0 !== ev0 || if1.rvalid1 !== ev1) begin
        n_fail++; $display("FAIL alt_rvalid[%0d]: got %b%b want %b%b", k, if1.rvalid0, if1.rvalid1, ev0, ev1);
      end
      if (ev0 || ev1) begin
        n_tests++;
        if (if1.rdata !== ed) begin
          n_fail++; $display("FAIL alt_rdata[%0d]: got %h want %h", k, if1.rdata, ed);
        end
      end
      tick();
      if (k == 3) drv(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_blank();
    drv(0, 0, 0, 1, 12, 3);
    @(negedge clk);
    n_tests++;
    if (if1.gnt1 !== 1'b1 || if1.gnt0 !== 1'b0 || if1.rom_addr !== 11'h003) begin
      n_fail++; $display("FAIL blank_gnt: got gnt %b%b addr %h want 01 003", if1.gnt0, if1.gnt1, if1.rom_addr);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    n_tests++;
    if (if1.rvalid1 !== 1'b1 || if1.rvalid0 !== 1'b0 || if1.rdata !== 8'h00) begin
      n_fail++; $display("FAIL blank_rsp: got rv %b%b rdata %h want 01 00", if1.rvalid0, if1.rvalid1, if1.rdata);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    drv(0, 0, 0, 1, 9, 9);
    @(negedge clk);
    n_tests++;
    if (if1.gnt1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_gnt1: got %b want 1", if1.gnt1);
    end
    tick();
    reset = 1'b1;
    drv(1, 3, 3, 1, 4, 4);
    @(negedge clk);
    n_tests++;
    if (if1.gnt0 !== 1'b0 || if1.gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL mid_gnt_in_reset: got %b%b want 00", if1.gnt0, if1.gnt1);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (if1.rvalid1 !== 1'b0 || if1.rvalid0 !== 1'b0 || if1.rdata !== 8'h00) begin
      n_fail++; $display("FAIL mid_discard: got rv %b%b rdata %h want 00 00", if1.rvalid0, if1.rvalid1, if1.rdata);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_tests++;
        if (if1.gnt0 !== 1'b1 || if1.gnt1 !== 1'b0) begin
          n_fail++; $display("FAIL mid_tie_after: got %b%b want 10", if1.gnt0, if1.gnt1);
        end
      end
      if (k < 2) begin
        n_tests++;
        if (if1.rvalid1 !== 1'b0) begin
          n_fail++; $display("FAIL mid_stale[%0d]: got rvalid1 %b want 0", k, if1.rvalid1);
        end
      end
      if (k == 2) begin
        n_tests++;
        if (if1.rvalid0 !== 1'b1 || if1.rdata !== mem[11'h333]) begin
          n_fail++; $display("FAIL mid_rsp0: got rvalid0 %b rdata %h want 1 %h", if1.rvalid0, if1.rdata, mem[11'h333]);
        end
      end
      tick();
      if (k == 0) drv(0, 0, 0, 1, 4, 4);
      if (k == 1) drv(0, 0, 0, 0, 0, 0);
    end
    tick(); tick();
  endtask

  task automatic test_no_bubble();
    drv(1, 2, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (if1.gnt0 !== (k < 3) || if1.gnt1 !== (k == 3)) begin
        n_fail++; $display("FAIL bubble[%0d]: got %b%b want %b%b", k, if1.gnt0, if1.gnt1, (k < 3), (k == 3));
      end
      tick();
      if (k == 2) drv(0, 0, 0, 1, 5, 1);
      if (k == 3) drv(0, 0, 0, 0, 0, 0);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_lat3();
    if3.req0 = 1'b1; if3.digit0 = 4'd8; if3.row0 = 4'd6;
    @(negedge clk);
    n_tests++;
    if (if3.gnt0 !== 1'b1 || if3.rom_addr !== 11'h386) begin
      n_fail++; $display("FAIL lat3_gnt: got gnt0 %b addr %h want 1 386", if3.gnt0, if3.rom_addr);
    end
    tick();
    if3.req0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (if3.rvalid0 !== (k == 4) || if3.rvalid1 !== 1'b0) begin
        n_fail++; $display("FAIL lat3_rvalid[%0d]: got %b%b want %b0", k, if3.rvalid0, if3.rvalid1, (k == 4));
      end
      if (k == 4) begin
        n_tests++;
        if (if3.rdata !== 8'hFE) begin
          n_fail++; $display("FAIL lat3_rdata: got %h want fe", if3.rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    rsp_t       q[$];
    rsp_t       e;
    logic       r0 = 0, r1 = 0, rst, g0, g1, ev0, ev1;
    logic [3:0] d0 = 0, w0 = 0, d1 = 0, w1 = 0;
    logic [10:0] ea;
    logic [7:0] exp_rdata = 8'h00;
    bit         last = 1'b1;
    bit         hold0 = 0, hold1 = 0;
    for (int c = 0; c < 400; c++) begin
      rst = (c == 0) || ($urandom_range(0, 39) == 0);
      if (!hold0) begin r0 = 1'($urandom_range(0, 1)); d0 = 4'($urandom); w0 = 4'($urandom); end
      if (!hold1) begin r1 = 1'($urandom_range(0, 1)); d1 = 4'($urandom); w1 = 4'($urandom); end
      reset = rst;
      drv(r0, d0, w0, r1, d1, w1);
      @(negedge clk);
      if (rst) begin
        g0 = 0; g1 = 0;
      end else if (r0 && r1) begin
        g0 = (last == 1'b1); g1 = !g0;
      end else begin
        g0 = r0; g1 = r1;
      end
      ea = g0 ? ref_addr(int'(d0), int'(w0)) : (g1 ? ref_addr(int'(d1), int'(w1)) : 11'd0);
      n_tests++;
      if (if1.gnt0 !== g0 || if1.gnt1 !== g1 || if1.rom_addr !== ea) begin
        n_fail++; $display("FAIL rnd_gnt[%0d]: got %b%b %h want %b%b %h", c, if1.gnt0, if1.gnt1, if1.rom_addr, g0, g1, ea);
      end
      ev0 = 0; ev1 = 0;
      if (q.size() > 0 && q[0].due == c) begin
        e = q.pop_front();
        ev0 = !e.id; ev1 = e.id;
        exp_rdata = e.data;
      end
      n_tests++;
      if (if1.rvalid0 !== ev0 || if1.rvalid1 !== ev1) begin
        n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", c, if1.rvalid0, if1.rvalid1, ev0, ev1);
      end
      if (c > 0) begin
        n_tests++;
        if (if1.rdata !== exp_rdata) begin
          n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, if1.rdata, exp_rdata);
        end
      end
      if (g0 || g1) begin
        e.id = g1; e.data = mem[ea]; e.due = c + 2;
        q.push_back(e);
      end
      hold0 = r0 && !g0;
      hold1 = r1 && !g1;
      if (rst) begin
        q.delete();
        last = 1'b1;
        exp_rdata = 8'h00;
      end else if (g0) begin
        last = 1'b0;
      end else if (g1) begin
        last = 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = (i < 16) ? 8'h00 : 8'((i * 37 + 11) ^ (i >> 3));
    mem[11'h302] = 8'h38;
    mem[11'h314] = 8'h78;
    mem[11'h374] = 8'h06;
    mem[11'h386] = 8'hFE;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    if3.req0 = 0; if3.digit0 = 0; if3.row0 = 0;
    if3.req1 = 0; if3.digit1 = 0; if3.row1 = 0;
    test_reset();
    test_single();
    test_alternate();
    test_blank();
    test_reset_midflight();
    test_no_bubble();
    test_lat3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
